// File: rtl/cdb_result_buffer.sv
// Per-FU result FIFO feeding one CDB producer slot: holds req while non-empty,
// pops on grant, supports flush, and flags a head entry starved of grants.
module cdb_result_buffer #(
    parameter int DEPTH       = 4,
    parameter int TAG_WIDTH   = 5,
    parameter int STALL_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_data,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    input  logic                       in_exception,
    output logic                       cdb_req,
    input  logic                       cdb_grant,
    output logic [31:0]                cdb_data,
    output logic [TAG_WIDTH-1:0]       cdb_tag,
    output logic                       cdb_exception,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       stall_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(STALL_LIMIT + 1);
    localparam int EW = 32 + TAG_WIDTH + 1;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          stall_err_q, stall_err_d;
    logic          push, pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign in_ready  = !full;
    assign cdb_req   = !empty;
    assign count     = count_q;
    assign stall_err = stall_err_q;
    assign {cdb_data, cdb_tag, cdb_exception} = mem_q[rd_ptr_q];

    // in_ready is independent of grant, so a full-cycle push is refused even on a pop.
    assign push = in_valid && in_ready && !flush;
    assign pop  = cdb_req && cdb_grant && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wait_cnt_d  = wait_cnt_q;
        stall_err_d = stall_err_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
        if (flush || pop || empty)
            wait_cnt_d = '0;
        else if (cdb_req && !cdb_grant && wait_cnt_q != WW'(STALL_LIMIT))
            wait_cnt_d = wait_cnt_q + 1'b1;
        // Set off the next count so the flag rises right after the limit-th stalled cycle.
        if (wait_cnt_d == WW'(STALL_LIMIT))
            stall_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wait_cnt_q  <= '0;
            stall_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_data, in_tag, in_exception};
    end
endmodule

// File: tb/tb_cdb_result_buffer.sv
// Bench for cdb_result_buffer: queue-based reference model checked every cycle,
// a directed vector table, hand-written corner sequences and random traffic.
module tb_cdb_result_buffer;
    localparam int DEPTH = 4;
    localparam int TW    = 5;
    localparam int LIM   = 16;

    logic          clk = 0;
    logic          rst_n, flush, in_valid, in_ready, in_exception;
    logic [31:0]   in_data, cdb_data;
    logic [TW-1:0] in_tag, cdb_tag;
    logic          cdb_req, cdb_grant, cdb_exception, empty, full, stall_err;
    logic [2:0]    count;

    cdb_result_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .STALL_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .in_exception(in_exception), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
        .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_exception(cdb_exception),
        .count(count), .empty(empty), .full(full), .stall_err(stall_err));

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] d; logic [TW-1:0] t; logic e; } ent_t;
    typedef struct {
        bit iv; int tag; bit gnt; bit fl;
        int e_cnt; bit e_req; bit e_full; int e_tag;
    } vec_t;

    ent_t mq[$];
    int   m_wait;
    bit   m_err;
    int   tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wait = 0;
        m_err  = 0;
    endtask

    // Next state straight from the rules: ready = not full, req = not empty.
    task automatic model_step(input bit iv, input ent_t en, input bit g, input bit f);
        bit req, rdy, p_push, p_pop;
        req    = mq.size() > 0;
        rdy    = mq.size() < DEPTH;
        p_push = iv && rdy && !f;
        p_pop  = req && g && !f;
        if (f) mq.delete();
        else begin
            if (p_pop)  void'(mq.pop_front());
            if (p_push) mq.push_back(en);
        end
        if (f || p_pop || !req) m_wait = 0;
        else if (m_wait < LIM)  m_wait++;
        if (m_wait == LIM) m_err = 1;
    endtask

    task automatic check_model();
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEPTH);
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("cdb_req", cdb_req, mq.size() > 0);
        chk("stall_err", stall_err, m_err);
        if (mq.size() > 0) begin
            chk("cdb_data", cdb_data, mq[0].d);
            chk("cdb_tag", cdb_tag, mq[0].t);
            chk("cdb_exc", cdb_exception, mq[0].e);
        end
    endtask

    task automatic cyc(input bit iv, input logic [31:0] d, input logic [TW-1:0] t,
                       input bit e, input bit g, input bit f);
        ent_t en;
        in_valid = iv; in_data = d; in_tag = t; in_exception = e;
        cdb_grant = g; flush = f;
        en = '{d: d, t: t, e: e};
        model_step(iv, en, g, f);
        @(posedge clk); #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; cdb_grant = 0; flush = 0;
        @(posedge clk); #1;
        model_reset();
        check_model();
        rst_n = 1;
    endtask

    vec_t tbl[15];

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; in_data = '0; in_tag = '0;
        in_exception = 0; cdb_grant = 0;
        model_reset();

        // Fill/refuse/drain, then a granted stream that wraps the pointers.
        tbl[0]  = '{1, 1, 0, 0, 1, 1, 0, 1};
        tbl[1]  = '{1, 2, 0, 0, 2, 1, 0, 1};
        tbl[2]  = '{1, 3, 0, 0, 3, 1, 0, 1};
        tbl[3]  = '{1, 4, 0, 0, 4, 1, 1, 1};
        tbl[4]  = '{1, 5, 1, 0, 3, 1, 0, 2};
        tbl[5]  = '{0, 0, 1, 0, 2, 1, 0, 3};
        tbl[6]  = '{0, 0, 1, 0, 1, 1, 0, 4};
        tbl[7]  = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 6, 0, 0, 1, 1, 0, 6};
        tbl[9]  = '{1, 7, 1, 0, 1, 1, 0, 7};
        tbl[10] = '{1, 8, 1, 0, 1, 1, 0, 8};
        tbl[11] = '{1, 9, 1, 0, 1, 1, 0, 9};
        tbl[12] = '{1, 10, 1, 0, 1, 1, 0, 10};
        tbl[13] = '{0, 0, 1, 1, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 1, 0, 0, 0, 0, 0};

        do_reset();
        chk("rst_req", cdb_req, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_empty", empty, 1);

        // Single push with grant held high from the push cycle.
        cyc(1, 32'hDEADBEEF, 3, 0, 1, 0);
        chk("single_req", cdb_req, 1);
        chk("single_data", cdb_data, 32'hDEADBEEF);
        chk("single_tag", cdb_tag, 3);
        cyc(0, 0, 0, 0, 1, 0);
        chk("single_cnt0", count, 0);
        chk("single_req0", cdb_req, 0);

        // Table: 5th push at full is refused although a pop happens that cycle.
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].iv, 32'hA000_0000 | tbl[i].tag, TW'(tbl[i].tag), tbl[i].tag[0],
                tbl[i].gnt, tbl[i].fl);
            chk($sformatf("tbl%0d_cnt", i), count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_req", i), cdb_req, tbl[i].e_req);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
            if (tbl[i].e_req) chk($sformatf("tbl%0d_tag", i), cdb_tag, tbl[i].e_tag);
        end

        // Simultaneous push and pop at count 2.
        cyc(1, 32'h11, 11, 0, 0, 0);
        cyc(1, 32'h12, 12, 1, 0, 0);
        cyc(1, 32'h13, 13, 0, 1, 0);
        chk("pp_cnt", count, 2);
        chk("pp_tag", cdb_tag, 12);
        cyc(0, 0, 0, 0, 1, 0);
        chk("pp_tag2", cdb_tag, 13);
        cyc(0, 0, 0, 0, 1, 0);

        // Flush at count 3 with concurrent push and grant.
        cyc(1, 32'h21, 21, 0, 0, 0);
        cyc(1, 32'h22, 22, 0, 0, 0);
        cyc(1, 32'h23, 23, 0, 0, 0);
        cyc(1, 32'h24, 24, 0, 1, 1);
        chk("fl_cnt", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_req", cdb_req, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("fl_req_after", cdb_req, 0);

        // Watchdog trips after 16 stalled cycles and is sticky through grant and flush.
        cyc(1, 32'h30, 30, 0, 0, 0);
        for (int i = 1; i <= LIM; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            if (i == LIM - 1) chk("wd_pre", stall_err, 0);
        end
        chk("wd_set", stall_err, 1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("wd_sticky", stall_err, 1);

        // Reset with two entries queued.
        cyc(1, 32'h41, 1, 0, 0, 0);
        cyc(1, 32'h42, 2, 0, 0, 0);
        chk("prerst_cnt", count, 2);
        do_reset();
        chk("rst2_cnt", count, 0);
        chk("rst2_req", cdb_req, 0);
        chk("rst2_ready", in_ready, 1);
        chk("rst2_err", stall_err, 0);

        // 15 stalled cycles then a grant must not trip.
        cyc(1, 32'h50, 5, 1, 0, 0);
        for (int i = 0; i < LIM - 1; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("wd_15", stall_err, 0);

        // Random traffic: balanced phase, then grant-starved phase with flushes.
        for (int i = 0; i < 1200; i++) begin
            int gp;
            gp = (i < 600) ? 50 : 8;
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc($urandom_range(0, 99) < 60, $urandom, TW'($urandom_range(0, 31)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 99) < gp,
                $urandom_range(0, 99) < 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdb_result_buffer.md
# cdb_result_buffer

Per-functional-unit result queue that sits between a functional unit's writeback stage and the dual-channel Common Data Bus. It stores completed results in a small FIFO and drives the head entry onto the FU's CDB producer slot. It holds `req` while entries are pending and pops on `grant`, so the FU never has to stall its pipeline waiting for arbitration. A flush clears the queue, and a starvation watchdog flags a head entry that waits too long.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `TAG_WIDTH`, 5: tag width; must match the CDB.
- `STALL_LIMIT`, 16: consecutive un-granted request cycles that trip the watchdog; ≥1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `flush`  in  1  discard all queued entries.
- `in_valid`  in  1  FU presents a completed result.
- `in_ready`  out  1  buffer can accept; equals `!full`.
- `in_data`  in  32  result value.
- `in_tag`  in  TAG_WIDTH  destination tag.
- `in_exception`  in  1  result carries an exception.
- `cdb_req`  out  1  request to the CDB arbiter; equals `!empty`.
- `cdb_grant`  in  1  this FU's grant bit, OR of both channels, combinational from `cdb_req`.
- `cdb_data`  out  32  head entry data.
- `cdb_tag`  out  TAG_WIDTH  head entry tag.
- `cdb_exception`  out  1  head entry exception.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `stall_err`  out  1  sticky watchdog flag.

## Operation
- **Storage:** circular FIFO with `wr_ptr`/`rd_ptr` of width $clog2(DEPTH), wrapping DEPTH-1 → 0. `count` is held separately, so full and empty are unambiguous.
- **Push:** `push = in_valid && in_ready && !flush`. Writes `{data, tag, exception}` at `wr_ptr`, then increments `wr_ptr`.
- **Pop:** `pop = cdb_req && cdb_grant && !flush`. Increments `rd_ptr`.
- **Count update:** push and pop in the same cycle leave `count` unchanged. Push alone adds 1; pop alone subtracts 1.
- **Full-cycle behaviour:** `in_ready` does not look at `cdb_grant`. A push offered while full is refused even if a pop happens in that cycle. This keeps grant off the FU ready path.
- **CDB drive:** `cdb_data`, `cdb_tag` and `cdb_exception` always reflect the entry at `rd_ptr`. Their value is don't-care when empty. The bench must check them only while `cdb_req` is 1.
- **No bypass:** an input always enters storage before it is requested.
- **`cdb_grant` while `cdb_req` is 0:** ignored; no pop.
- **Flush:**
  - Next cycle: `wr_ptr = rd_ptr = 0`, `count = 0`.
  - Flush has priority over push and pop in the same cycle.
  - `cdb_req` is state-derived, so it stays asserted during the flush cycle. If granted, the CDB still captures that entry. Consumers are flushed by the same event, so this is acceptable.
- **Watchdog:**
  - `wait_cnt` has width $clog2(STALL_LIMIT+1) and saturates.
  - It increments when `cdb_req && !cdb_grant`.
  - It clears on pop, flush, or empty.
  - When `wait_cnt == STALL_LIMIT`, `stall_err` sets and stays set until reset. Flush does not clear it.
- **Reset:** pointers 0, `count` 0, `wait_cnt` 0. Outputs: `cdb_req` 0, `in_ready` 1, `empty` 1, `full` 0, `stall_err` 0. Storage contents are not reset.

## Timing
- **Push → request:** push at edge N gives `cdb_req`=1 in cycle N+1.
- **Grant → broadcast:** grant in cycle N+1 means the CDB registers the result at edge N+2, so consumer-visible `valid` is in cycle N+2. Minimum latency from FU handoff to CDB valid is 2 cycles.
- **Back-to-back throughput:** 1 entry/cycle if granted every cycle. The head advances at the pop edge, and the next entry's data is presented in the following cycle with `cdb_req` held.
- **Full:** `full` rises in the cycle after the DEPTH-th push. `in_ready` falls in that same cycle and recovers in the cycle after the first pop.
- **Flush:** `cdb_req`=0 in the cycle after flush, unless a push in that next cycle refills the queue.
- **Watchdog:** `stall_err` rises in the cycle after the STALL_LIMIT-th consecutive un-granted request cycle.
- **Reset mid-operation:** queued entries are lost and all outputs take reset values at the next edge. A request in flight in the reset cycle is not guaranteed.

## Test plan
- **Single push, grant in the first request cycle:** push `{0xDEADBEEF, tag 3, exc 0}`, grant held high. Expect `cdb_req`=1 one cycle later with that data; `count` returns 0 the cycle after; `cdb_req`=0.
- **Fill to DEPTH=4 with no grant:**
  - Expect `full`=1, `in_ready`=0, `count`=4.
  - A 5th `in_valid` is refused.
  - Then grant 4 consecutive cycles: tags pop in FIFO order 1, 2, 3, 4, exercising pointer wrap on a following refill.
- **Simultaneous push and pop at `count`=2:** `count` stays 2; output order is preserved.
- **Flush with `count`=3 plus concurrent push and grant:** next cycle `count`=0, `empty`=1, `cdb_req`=0; the pushed entry is not stored.
- **Watchdog:** hold one entry with no grant for 16 cycles, STALL_LIMIT=16. `stall_err`=1 in cycle 17 and stays 1 after a later grant and flush. A 15-cycle wait followed by a grant leaves `stall_err`=0.
- **Reset asserted with `count`=2:** next cycle `count`=0, `cdb_req`=0, `in_ready`=1, `stall_err`=0.
